// File: rtl/alu_seq_pkg.sv
// Shared constants, opcode encodings and FSM state type for the ALU sequencer.
package alu_seq_pkg;

    localparam int DATA_W = 4;
    localparam int NREGS  = 4;
    localparam int REG_AW = 2;
    localparam int CNT_W  = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ZERO  = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD   = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b010;
    localparam logic [OP_W-1:0] OP_AND   = 3'b011;
    localparam logic [OP_W-1:0] OP_OR    = 3'b100;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'b101;
    localparam logic [OP_W-1:0] OP_NOTB  = 3'b110;
    localparam logic [OP_W-1:0] OP_ZERO2 = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU datapath and status/debug bundle of the sequencer.
// slave = sequencer view, master = host/ALU view.
interface alu_sequencer_if #(
    parameter int DATA_W = alu_seq_pkg::DATA_W,
    parameter int REG_AW = alu_seq_pkg::REG_AW,
    parameter int CNT_W  = alu_seq_pkg::CNT_W
);
    logic              instr_valid;
    logic              instr_ready;
    logic              instr_load;
    logic [2:0]        instr_op;
    logic [REG_AW-1:0] instr_rd;
    logic [REG_AW-1:0] instr_rs1;
    logic [REG_AW-1:0] instr_rs2;
    logic [DATA_W-1:0] instr_imm;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              done;
    logic              zero_flag;
    logic [CNT_W-1:0]  retired_cnt;
    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport slave (
        input  instr_valid, instr_load, instr_op, instr_rd, instr_rs1, instr_rs2,
               instr_imm, alu_result, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_op, done, zero_flag, retired_cnt, dbg_data
    );

    modport master (
        output instr_valid, instr_load, instr_op, instr_rd, instr_rs1, instr_rs2,
               instr_imm, alu_result, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_op, done, zero_flag, retired_cnt, dbg_data
    );
endinterface

// File: rtl/alu_seq_regfile.sv
// Flop-based register file: one synchronous write port, two operand read ports
// and a debug read port, all reads combinational (pre-write value during a write).
module alu_seq_regfile #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 4,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [REG_AW-1:0] raddr_dbg,
    output logic [DATA_W-1:0] rdata_dbg
);
    logic [DATA_W-1:0] mem_q [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (we && (waddr == REG_AW'(gi))) begin
                    mem_q[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata_a   = mem_q[raddr_a];
    assign rdata_b   = mem_q[raddr_b];
    assign rdata_dbg = mem_q[raddr_dbg];
endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer driving an external combinational ALU: loads retire in
// one cycle, ALU ops take an EXEC cycle and write the result back.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = alu_seq_pkg::DATA_W,
    parameter int NREGS  = alu_seq_pkg::NREGS,
    parameter int REG_AW = alu_seq_pkg::REG_AW,
    parameter int CNT_W  = alu_seq_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus
);
    state_e            state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic              done_q, done_d;
    logic              zero_q, zero_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    alu_seq_regfile #(
        .DATA_W(DATA_W),
        .NREGS (NREGS),
        .REG_AW(REG_AW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr_a  (bus.instr_rs1),
        .rdata_a  (rs1_data),
        .raddr_b  (bus.instr_rs2),
        .rdata_b  (rs2_data),
        .raddr_dbg(bus.dbg_addr),
        .rdata_dbg(bus.dbg_data)
    );

    assign bus.instr_ready = (state_q == IDLE) && !rst;
    assign accept          = bus.instr_valid && bus.instr_ready;

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = rd_q;
        rf_wdata = bus.alu_result;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.instr_load) begin
                        rf_we    = 1'b1;
                        rf_waddr = bus.instr_rd;
                        rf_wdata = bus.instr_imm;
                    end else begin
                        alu_a_d  = rs1_data;
                        alu_b_d  = rs2_data;
                        alu_op_d = bus.instr_op;
                        rd_d     = bus.instr_rd;
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                rf_we   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every register-file write retires exactly one instruction.
        if (rf_we) begin
            done_d = 1'b1;
            zero_d = (rf_wdata == '0);
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_q     <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.done        = done_q;
    assign bus.zero_flag   = zero_q;
    assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus random bench for alu_sequencer against an arithmetic reference
// model; includes a behavioural stand-in for the external 4-bit ALU.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_sequencer_if #(.DATA_W(4), .REG_AW(2), .CNT_W(8)) bus ();

    alu_sequencer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // External ALU stand-in
    always_comb begin
        case (bus.alu_op)
            OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
            OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
            OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
            OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
            OP_NOTA: bus.alu_result = ~bus.alu_a;
            OP_NOTB: bus.alu_result = ~bus.alu_b;
            default: bus.alu_result = 4'h0;
        endcase
    end

    int checks = 0;
    int errors = 0;
    int rf_m [4];
    int cnt_m;
    int zero_m;
    time t_acc;

    function automatic int alu_ref(input int op, input int a, input int b);
        case (op)
            1:       return (a + b) % 16;
            2:       return (a - b + 16) % 16;
            3:       return a & b;
            4:       return a | b;
            5:       return 15 - a;
            6:       return 15 - b;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the instruction retires.
    task automatic send(input bit load, input int op, input int rd, input int rs1,
                        input int rs2, input int imm);
        int n;
        int res;
        bus.instr_load  = load;
        bus.instr_op    = 3'(op);
        bus.instr_rd    = 2'(rd);
        bus.instr_rs1   = 2'(rs1);
        bus.instr_rs2   = 2'(rs2);
        bus.instr_imm   = 4'(imm);
        bus.instr_valid = 1'b1;
        n = 0;
        while (!bus.instr_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(bus.instr_ready), 32'd1);
        @(posedge clk);
        t_acc = $time;
        #1 bus.instr_valid = 1'b0;
        if (load) begin
            rf_m[rd] = imm;
            cnt_m    = (cnt_m + 1) % 256;
            zero_m   = (imm == 0) ? 1 : 0;
            @(negedge clk);
            bus.dbg_addr = 2'(rd);
            #1;
            chk("ld_done", 32'(bus.done), 32'd1);
            chk("ld_zero", 32'(bus.zero_flag), 32'(zero_m));
            chk("ld_cnt", 32'(bus.retired_cnt), 32'(cnt_m));
            chk("ld_dbg", 32'(bus.dbg_data), 32'(imm));
        end else begin
            @(negedge clk);
            bus.dbg_addr = 2'(rd);
            #1;
            chk("op_a", 32'(bus.alu_a), 32'(rf_m[rs1]));
            chk("op_b", 32'(bus.alu_b), 32'(rf_m[rs2]));
            chk("op_code", 32'(bus.alu_op), 32'(op));
            chk("op_nodone", 32'(bus.done), 32'd0);
            chk("op_busy", 32'(bus.instr_ready), 32'd0);
            chk("op_prewrite", 32'(bus.dbg_data), 32'(rf_m[rd]));
            res      = alu_ref(op, rf_m[rs1], rf_m[rs2]);
            rf_m[rd] = res;
            cnt_m    = (cnt_m + 1) % 256;
            zero_m   = (res == 0) ? 1 : 0;
            @(negedge clk);
            #1;
            chk("wb_done", 32'(bus.done), 32'd1);
            chk("wb_zero", 32'(bus.zero_flag), 32'(zero_m));
            chk("wb_cnt", 32'(bus.retired_cnt), 32'(cnt_m));
            chk("wb_data", 32'(bus.dbg_data), 32'(res));
        end
    endtask

    initial begin
        time t_first;
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_load  = 1'b0;
        bus.instr_op    = '0;
        bus.instr_rd    = '0;
        bus.instr_rs1   = '0;
        bus.instr_rs2   = '0;
        bus.instr_imm   = '0;
        bus.dbg_addr    = '0;
        foreach (rf_m[i]) rf_m[i] = 0;
        cnt_m  = 0;
        zero_m = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.instr_ready), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cnt", 32'(bus.retired_cnt), 32'd0);
        chk("rst_a", 32'(bus.alu_a), 32'd0);
        chk("rst_zero", 32'(bus.zero_flag), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back loads, ADD, SUB wrap, ADD to zero
        send(1, 0, 1, 0, 0, 9);
        send(1, 0, 2, 0, 0, 5);
        send(0, 1, 3, 1, 2, 0);
        chk("add_r3", 32'(rf_m[3]), 32'hE);
        send(0, 2, 0, 2, 1, 0);
        send(1, 0, 1, 0, 0, 15);
        send(1, 0, 2, 0, 0, 1);
        send(0, 1, 0, 1, 2, 0);

        // Two ALU ops back to back; second reads first's rd
        send(0, 1, 3, 1, 2, 0);
        t_first = t_acc;
        send(0, 2, 0, 3, 3, 0);
        chk("op_spacing", 32'(t_acc - t_first), 32'd20);

        // ~B, zero ops, rs1==rs2==rd
        send(1, 0, 2, 0, 0, 5);
        send(0, 6, 1, 1, 2, 0);
        send(0, 0, 3, 1, 2, 0);
        send(0, 7, 3, 1, 2, 0);
        send(1, 0, 2, 0, 0, 6);
        send(0, 1, 2, 2, 2, 0);

        // Reset during EXEC aborts the instruction
        send(1, 0, 3, 0, 0, 11);
        bus.instr_load  = 1'b0;
        bus.instr_op    = OP_ADD;
        bus.instr_rd    = 2'd3;
        bus.instr_rs1   = 2'd1;
        bus.instr_rs2   = 2'd2;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        bus.dbg_addr = 2'd3;
        #1;
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_r3", 32'(bus.dbg_data), 32'd0);
        chk("abort_a", 32'(bus.alu_a), 32'd0);
        chk("abort_b", 32'(bus.alu_b), 32'd0);
        chk("abort_op", 32'(bus.alu_op), 32'd0);
        chk("abort_cnt", 32'(bus.retired_cnt), 32'd0);
        chk("abort_zero", 32'(bus.zero_flag), 32'd0);
        rst = 1'b0;
        foreach (rf_m[i]) rf_m[i] = 0;
        cnt_m  = 0;
        zero_m = 0;
        @(negedge clk);
        send(1, 0, 1, 0, 0, 7);
        send(0, 4, 3, 1, 2, 0);

        // Random traffic; long enough to wrap retired_cnt
        for (int k = 0; k < 300; k++) begin
            int ld;
            ld = ($urandom_range(0, 2) == 0) ? 1 : 0;
            send(ld[0], int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 15)));
        end

        @(negedge clk);
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_ready", 32'(bus.instr_ready), 32'd1);
        chk("final_cnt", 32'(bus.retired_cnt), 32'(cnt_m));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
